// File: rtl/jpeg_inverse_zigzag_if.sv
// Stream bundle for jpeg_inverse_zigzag: zigzag-order coefficients in, raster-order out.
// in_eob exists only when JPEG_INVZZ_EOB_EN is defined.
interface jpeg_inverse_zigzag_if #(
    parameter int DW = 12
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
`ifdef JPEG_INVZZ_EOB_EN
    logic          in_eob;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sob;
    logic          out_last;

    modport master (
        output in_valid, in_data,
`ifdef JPEG_INVZZ_EOB_EN
        output in_eob,
`endif
        output out_ready,
        input  in_ready, out_valid, out_data, out_sob, out_last
    );

    modport slave (
        input  in_valid, in_data,
`ifdef JPEG_INVZZ_EOB_EN
        input  in_eob,
`endif
        input  out_ready,
        output in_ready, out_valid, out_data, out_sob, out_last
    );
endinterface

// File: rtl/jpeg_inverse_zigzag.sv
// Inverse JPEG zigzag reorder with ping-pong 64-entry banks, one coefficient per clock.
// Optional early end-of-block support is enabled by defining JPEG_INVZZ_EOB_EN.
module jpeg_inverse_zigzag #(
    parameter int DW = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    jpeg_inverse_zigzag_if.slave bus
);
    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_e;

    // Zigzag index -> raster address.
    localparam logic [5:0] ZZ2R [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    bank_state_e   bank_q [2];
    bank_state_e   bank_d [2];
    logic [5:0]    wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic          wbank_q, wbank_d, rbank_q, rbank_d;
    logic          out_valid_q, out_valid_d;
    logic          out_sob_q, out_sob_d, out_last_q, out_last_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [DW-1:0] mem_q [2][64];
    logic [DW-1:0] rd_word;
    logic          in_ready, wr_en, wr_close, fetch, fetch_last;

    // Bank state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
        end
    end

    // Bank next state: writer fills/closes bank[wbank], reader frees bank[rbank].
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            // NOTE: default first so every path assigns bank_d and no latch is inferred.
            bank_d[b] = bank_q[b];
            unique case (bank_q[b])
                BANK_EMPTY:   if (wr_en && wbank_q == b[0])
                                  bank_d[b] = wr_close ? BANK_FULL : BANK_FILLING;
                BANK_FILLING: if (wr_close && wbank_q == b[0]) bank_d[b] = BANK_FULL;
                BANK_FULL:    if (fetch_last && rbank_q == b[0]) bank_d[b] = BANK_EMPTY;
                default:      bank_d[b] = BANK_EMPTY;
            endcase
        end
    end

    // FSM outputs: handshake and fetch strobes.
    always_comb begin
        in_ready   = (bank_q[wbank_q] != BANK_FULL);
        wr_en      = bus.in_valid && in_ready;
`ifdef JPEG_INVZZ_EOB_EN
        wr_close   = wr_en && ((wcnt_q == 6'd63) || bus.in_eob);
`else
        wr_close   = wr_en && (wcnt_q == 6'd63);
`endif
        fetch      = (bank_q[rbank_q] == BANK_FULL) && (!out_valid_q || bus.out_ready);
        fetch_last = fetch && (rcnt_q == 6'd63);
    end

`ifdef JPEG_INVZZ_EOB_EN
    logic [63:0] mask_q [2];

    // Written mask: unwritten raster slots of an early-closed block read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q[0] <= '0;
            mask_q[1] <= '0;
        end else begin
            if (fetch_last) mask_q[rbank_q] <= '0;
            if (wr_en)      mask_q[wbank_q][ZZ2R[wcnt_q]] <= 1'b1;
        end
    end

    assign rd_word = mask_q[rbank_q][rcnt_q] ? mem_q[rbank_q][rcnt_q] : '0;
`else
    assign rd_word = mem_q[rbank_q][rcnt_q];
`endif

    // NOTE: coefficient storage is deliberately not reset; bank states alone say what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wbank_q][ZZ2R[wcnt_q]] <= bus.in_data;
    end

    always_comb begin
        wcnt_d      = wcnt_q;
        wbank_d     = wbank_q;
        rcnt_d      = rcnt_q;
        rbank_d     = rbank_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sob_d   = out_sob_q;
        out_last_d  = out_last_q;
        if (wr_en) begin
            wcnt_d = wr_close ? 6'd0 : wcnt_q + 6'd1;
            if (wr_close) wbank_d = ~wbank_q;
        end
        if (fetch) begin
            rcnt_d      = rcnt_q + 6'd1;
            if (fetch_last) rbank_d = ~rbank_q;
            out_valid_d = 1'b1;
            out_data_d  = rd_word;
            out_sob_d   = (rcnt_q == 6'd0);
            out_last_d  = (rcnt_q == 6'd63);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q      <= '0;
            wbank_q     <= 1'b0;
            rcnt_q      <= '0;
            rbank_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sob_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            wcnt_q      <= wcnt_d;
            wbank_q     <= wbank_d;
            rcnt_q      <= rcnt_d;
            rbank_q     <= rbank_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sob_q   <= out_sob_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sob   = out_sob_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_jpeg_inverse_zigzag.sv
// Self-checking bench for jpeg_inverse_zigzag against a diagonal-walk zigzag model.
// Define JPEG_INVZZ_EOB_EN to also exercise early end-of-block.
module tb_jpeg_inverse_zigzag;
    localparam int DW = 12;

    typedef struct {
        logic [DW-1:0] data;
        logic          sob;
        logic          last;
        int            cyc;
    } obs_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          eob;
    } stim_t;

    logic clk;
    logic rst;

    jpeg_inverse_zigzag_if #(.DW(DW)) bus ();

    jpeg_inverse_zigzag #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     tests_run = 0;
    int     failures  = 0;
    int     zz_pos [64];
    stim_t  stim_q [$];
    obs_t   got_q  [$];
    obs_t   exp_q  [$];
    int     sent;
    int     cyc;
    int     last_acc_cyc;
    int     stall_cnt;

    // Raster position of each zigzag index, from walking the anti-diagonals.
    function automatic void build_zigzag();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            for (int j = 0; j <= hi - lo; j++) begin
                int row = (s % 2 == 1) ? lo + j : hi - j;
                zz_pos[k] = row * 8 + (s - row);
                k++;
            end
        end
    endfunction

    function automatic void add_coef(input logic [DW-1:0] d, input logic eob);
        stim_t s;
        s.data = d;
        s.eob  = eob;
        stim_q.push_back(s);
    endfunction

    // Expected raster block from stim_q[base +: n]; unwritten slots are zero.
    function automatic void model_block(input int base, input int n);
        logic [DW-1:0] img [64];
        obs_t e;
        for (int r = 0; r < 64; r++) img[r] = '0;
        for (int k = 0; k < n; k++) img[zz_pos[k]] = stim_q[base + k].data;
        for (int r = 0; r < 64; r++) begin
            e.data = img[r];
            e.sob  = (r == 0);
            e.last = (r == 63);
            e.cyc  = 0;
            exp_q.push_back(e);
        end
    endfunction

    function automatic void add_random_block();
        int base = stim_q.size();
        for (int k = 0; k < 64; k++) add_coef(DW'($urandom_range(0, (1 << DW) - 1)), 1'b0);
        model_block(base, 64);
    endfunction

    // One clock: drive at the negedge, sample 1ns later, record handshakes.
    task automatic cycle(input logic ordy);
        obs_t o;
        bus.in_valid = (sent < stim_q.size());
        bus.in_data  = '0;
`ifdef JPEG_INVZZ_EOB_EN
        bus.in_eob   = 1'b0;
`endif
        if (bus.in_valid) begin
            bus.in_data = stim_q[sent].data;
`ifdef JPEG_INVZZ_EOB_EN
            bus.in_eob  = stim_q[sent].eob;
`endif
        end
        bus.out_ready = ordy;
        #1;
        if (bus.in_valid && !bus.in_ready) stall_cnt++;
        if (bus.in_valid && bus.in_ready) begin
            sent++;
            last_acc_cyc = cyc;
        end
        if (bus.out_valid && bus.out_ready) begin
            o.data = bus.out_data;
            o.sob  = bus.out_sob;
            o.last = bus.out_last;
            o.cyc  = cyc;
            got_q.push_back(o);
        end
        @(negedge clk);
        cyc++;
    endtask

    // mode 0: out_ready=1, 1: out_ready=0, 2: out_ready toggles each cycle.
    task automatic run(input int target, input int budget, input int mode);
        int left = budget;
        while (got_q.size() < target && left > 0) begin
            cycle(mode == 2 ? cyc[0] : (mode == 0));
            left--;
        end
    endtask

    task automatic begin_test();
        stim_q.delete();
        got_q.delete();
        exp_q.delete();
        sent = 0;
        cyc = 0;
        last_acc_cyc = -1;
        stall_cnt = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
`ifdef JPEG_INVZZ_EOB_EN
        bus.in_eob    = 1'b0;
`endif
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        begin_test();
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
            bus.out_sob !== 1'b0 || bus.out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h sob=%b last=%b, required 1 0 000 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_sob, bus.out_last);
        end
    endtask

    task automatic test_single_block();
        int first_vals [9] = '{0, 1, 5, 6, 14, 15, 27, 28, 2};
        begin_test();
        for (int k = 0; k < 64; k++) add_coef(DW'(k), 1'b0);
        model_block(0, 64);
        run(64, 300, 0);
        for (int i = 0; i < 64; i++) begin
            tests_run++;
            if (i >= got_q.size()) begin
                failures++;
                $display("FAIL single_block[%0d]: no output, required %h", i, exp_q[i].data);
            end else if ({got_q[i].data, got_q[i].sob, got_q[i].last} !==
                         {exp_q[i].data, exp_q[i].sob, exp_q[i].last}) begin
                failures++;
                $display("FAIL single_block[%0d]: got %h sob=%b last=%b, required %h sob=%b last=%b", i,
                         got_q[i].data, got_q[i].sob, got_q[i].last, exp_q[i].data, exp_q[i].sob, exp_q[i].last);
            end
        end
        if (got_q.size() >= 64) begin
            for (int i = 0; i < 9; i++) begin
                tests_run++;
                if (got_q[i].data !== DW'(first_vals[i])) begin
                    failures++;
                    $display("FAIL single_raster_const[%0d]: got %0d, required %0d", i, got_q[i].data, first_vals[i]);
                end
            end
            tests_run++;
            if (got_q[63].data !== DW'(63)) begin
                failures++;
                $display("FAIL single_raster_63: got %0d, required 63", got_q[63].data);
            end
            // Accept cycle of coefficient 63 to the cycle raster 0 is taken downstream.
            tests_run++;
            if (got_q[0].cyc - last_acc_cyc != 2) begin
                failures++;
                $display("FAIL single_latency: got %0d cycles, required 2", got_q[0].cyc - last_acc_cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        begin_test();
        for (int b = 0; b < 3; b++) add_random_block();
        run(192, 400, 0);
        for (int i = 0; i < 192; i++) begin
            tests_run++;
            if (i >= got_q.size()) begin
                failures++;
                $display("FAIL b2b[%0d]: no output, required %h", i, exp_q[i].data);
            end else if ({got_q[i].data, got_q[i].sob, got_q[i].last} !==
                         {exp_q[i].data, exp_q[i].sob, exp_q[i].last}) begin
                failures++;
                $display("FAIL b2b[%0d]: got %h sob=%b last=%b, required %h sob=%b last=%b", i,
                         got_q[i].data, got_q[i].sob, got_q[i].last, exp_q[i].data, exp_q[i].sob, exp_q[i].last);
            end
            if (i > 0 && i < got_q.size() && got_q[i].cyc != got_q[i-1].cyc + 1) gaps++;
        end
        tests_run++;
        if (stall_cnt != 0) begin
            failures++;
            $display("FAIL b2b_in_ready: got %0d stalled cycles, required 0", stall_cnt);
        end
        tests_run++;
        if (gaps != 0) begin
            failures++;
            $display("FAIL b2b_output_gaps: got %0d gaps, required 0", gaps);
        end
    endtask

    task automatic test_backpressure();
        begin_test();
        for (int b = 0; b < 3; b++) add_random_block();
        run(1, 150, 1);
        #1;
        tests_run++;
        if (sent != 128 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_accepts: got %0d accepts in_ready=%b, required 128 accepts in_ready=0", sent, bus.in_ready);
        end
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0].data || bus.out_sob !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold: got valid=%b data=%h sob=%b, required valid=1 data=%h sob=1",
                     bus.out_valid, bus.out_data, bus.out_sob, exp_q[0].data);
        end
        run(192, 500, 0);
        for (int i = 0; i < 192; i++) begin
            tests_run++;
            if (i >= got_q.size()) begin
                failures++;
                $display("FAIL bp_drain[%0d]: no output, required %h", i, exp_q[i].data);
            end else if ({got_q[i].data, got_q[i].sob, got_q[i].last} !==
                         {exp_q[i].data, exp_q[i].sob, exp_q[i].last}) begin
                failures++;
                $display("FAIL bp_drain[%0d]: got %h sob=%b last=%b, required %h sob=%b last=%b", i,
                         got_q[i].data, got_q[i].sob, got_q[i].last, exp_q[i].data, exp_q[i].sob, exp_q[i].last);
            end
        end
    endtask

    task automatic test_reset_mid();
        begin_test();
        for (int k = 0; k < 30; k++) add_coef(DW'($urandom_range(0, (1 << DW) - 1)), 1'b0);
        run(1, 30, 0);
        tests_run++;
        if (sent != 30) begin
            failures++;
            $display("FAIL rst_mid_prefill: got %0d accepts, required 30", sent);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_state: got out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
        stim_q.delete();
        got_q.delete();
        sent = 0;
        add_random_block();
        run(64, 300, 0);
        run(1000, 10, 0);
        tests_run++;
        if (got_q.size() != 64) begin
            failures++;
            $display("FAIL rst_mid_count: got %0d outputs, required 64", got_q.size());
        end
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            tests_run++;
            if ({got_q[i].data, got_q[i].sob, got_q[i].last} !== {exp_q[i].data, exp_q[i].sob, exp_q[i].last}) begin
                failures++;
                $display("FAIL rst_mid_block[%0d]: got %h sob=%b last=%b, required %h sob=%b last=%b", i,
                         got_q[i].data, got_q[i].sob, got_q[i].last, exp_q[i].data, exp_q[i].sob, exp_q[i].last);
            end
        end
    endtask

`ifdef JPEG_INVZZ_EOB_EN
    task automatic test_eob();
        int n_max = 0;
        begin_test();
        for (int k = 0; k < 10; k++) add_coef(12'h7FF, k == 9);
        model_block(0, 10);
        add_random_block();
        // Short block back into the first bank: stale 0x7FF slots must read as zero.
        for (int k = 0; k < 3; k++) add_coef(DW'($urandom_range(0, 2047)), k == 2);
        model_block(74, 3);
        run(192, 500, 0);
        for (int i = 0; i < 192; i++) begin
            tests_run++;
            if (i >= got_q.size()) begin
                failures++;
                $display("FAIL eob[%0d]: no output, required %h", i, exp_q[i].data);
            end else if ({got_q[i].data, got_q[i].sob, got_q[i].last} !==
                         {exp_q[i].data, exp_q[i].sob, exp_q[i].last}) begin
                failures++;
                $display("FAIL eob[%0d]: got %h sob=%b last=%b, required %h sob=%b last=%b", i,
                         got_q[i].data, got_q[i].sob, got_q[i].last, exp_q[i].data, exp_q[i].sob, exp_q[i].last);
            end
        end
        for (int i = 0; i < 64 && i < got_q.size(); i++)
            if (got_q[i].data === 12'h7FF) n_max++;
        tests_run++;
        if (n_max != 10) begin
            failures++;
            $display("FAIL eob_count_7ff: got %0d, required 10", n_max);
        end
    endtask
`endif

    task automatic test_toggle_ready();
        begin_test();
        for (int b = 0; b < 2; b++) add_random_block();
        run(128, 600, 2);
        for (int i = 0; i < 128; i++) begin
            tests_run++;
            if (i >= got_q.size()) begin
                failures++;
                $display("FAIL toggle[%0d]: no output, required %h", i, exp_q[i].data);
            end else if ({got_q[i].data, got_q[i].sob, got_q[i].last} !==
                         {exp_q[i].data, exp_q[i].sob, exp_q[i].last}) begin
                failures++;
                $display("FAIL toggle[%0d]: got %h sob=%b last=%b, required %h sob=%b last=%b", i,
                         got_q[i].data, got_q[i].sob, got_q[i].last, exp_q[i].data, exp_q[i].sob, exp_q[i].last);
            end
        end
        for (int i = 0; i + 1 < got_q.size(); i++) begin
            if (got_q[i].last) begin
                tests_run++;
                if (got_q[i+1].sob !== 1'b1) begin
                    failures++;
                    $display("FAIL toggle_last_sob[%0d]: next sob=%b, required 1", i, got_q[i+1].sob);
                end
            end
        end
    endtask

    initial begin
        build_zigzag();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
`ifdef JPEG_INVZZ_EOB_EN
        bus.in_eob    = 1'b0;
`endif
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef JPEG_INVZZ_EOB_EN
        test_eob();
`endif
        test_toggle_ready();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
